// File: rtl/vga_frame_sequencer.sv
// 640x480@60 raster timing, pixel-stage enables/coordinates and frame-store arbitration.
// Latency: enables/coords/frame_tick 1 cycle from counters, syncs 2 cycles; arbiter outputs registered.
// Backpressure: none on the raster; game writes wait (PENDING) until the vertical blanking window.
module vga_frame_sequencer #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int SCORE_H   = 40,
   parameter int COORD_BIT = 10
) (
   input  logic                 clock_25,
   input  logic                 reset,
   input  logic                 game_running,
   input  logic                 update_req,
   input  logic                 update_done,
   output logic                 update_grant,
   output logic                 update_overrun,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 display_area,
   output logic                 game_enable,
   output logic                 score_time_enable,
   output logic [COORD_BIT-1:0] pixel_x,
   output logic [COORD_BIT-1:0] pixel_y,
   output logic                 frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COORD_BIT-1:0] H_ACT_C   = COORD_BIT'(H_ACTIVE);
   localparam logic [COORD_BIT-1:0] H_SS_C    = COORD_BIT'(H_ACTIVE + H_FP);
   localparam logic [COORD_BIT-1:0] H_SE_C    = COORD_BIT'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COORD_BIT-1:0] H_LAST_C  = COORD_BIT'(H_TOTAL - 1);
   localparam logic [COORD_BIT-1:0] V_ACT_C   = COORD_BIT'(V_ACTIVE);
   localparam logic [COORD_BIT-1:0] V_SS_C    = COORD_BIT'(V_ACTIVE + V_FP);
   localparam logic [COORD_BIT-1:0] V_SE_C    = COORD_BIT'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [COORD_BIT-1:0] V_LAST_C  = COORD_BIT'(V_TOTAL - 1);
   localparam logic [COORD_BIT-1:0] SCORE_C   = COORD_BIT'(SCORE_H);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_GRANTED
   } arb_state_t;

   logic [COORD_BIT-1:0] h_cnt_q, h_cnt_d;
   logic [COORD_BIT-1:0] v_cnt_q, v_cnt_d;

   logic                 display_area_q, display_area_d;
   logic                 game_enable_q, game_enable_d;
   logic                 score_time_enable_q, score_time_enable_d;
   logic [COORD_BIT-1:0] pixel_x_q, pixel_x_d;
   logic [COORD_BIT-1:0] pixel_y_q, pixel_y_d;
   logic                 frame_tick_q, frame_tick_d;
   logic                 hsync_s1_q, hsync_s1_d;
   logic                 vsync_s1_q, vsync_s1_d;
   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;

   arb_state_t           state_q;
   logic                 update_grant_q;
   logic                 update_overrun_q;

   logic                 visible;
   logic                 in_score;
   logic                 grant_ok;
   logic                 window_open;
   logic                 frame_end;

   always_comb begin
      h_cnt_d = h_cnt_q + 1'b1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST_C) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
      end
   end

   always_comb begin
      visible             = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
      in_score            = v_cnt_q < SCORE_C;
      display_area_d      = visible;
      pixel_x_d           = visible ? h_cnt_q : '0;
      pixel_y_d           = visible ? v_cnt_q : '0;
      score_time_enable_d = visible && in_score;
      game_enable_d       = visible && !in_score && game_running;
      frame_tick_d        = (h_cnt_q == '0) && (v_cnt_q == V_ACT_C);
      hsync_s1_d          = !((h_cnt_q >= H_SS_C) && (h_cnt_q < H_SE_C));
      vsync_s1_d          = !((v_cnt_q >= V_SS_C) && (v_cnt_q < V_SE_C));
      // Second sync stage lines the syncs up with the registered colour output.
      hsync_d             = hsync_s1_q;
      vsync_d             = vsync_s1_q;
   end

   always_ff @(posedge clock_25) begin
      if (reset) begin
         h_cnt_q             <= '0;
         v_cnt_q             <= '0;
         display_area_q      <= 1'b0;
         game_enable_q       <= 1'b0;
         score_time_enable_q <= 1'b0;
         pixel_x_q           <= '0;
         pixel_y_q           <= '0;
         frame_tick_q        <= 1'b0;
         hsync_s1_q          <= 1'b1;
         vsync_s1_q          <= 1'b1;
         hsync_q             <= 1'b1;
         vsync_q             <= 1'b1;
      end else begin
         h_cnt_q             <= h_cnt_d;
         v_cnt_q             <= v_cnt_d;
         display_area_q      <= display_area_d;
         game_enable_q       <= game_enable_d;
         score_time_enable_q <= score_time_enable_d;
         pixel_x_q           <= pixel_x_d;
         pixel_y_q           <= pixel_y_d;
         frame_tick_q        <= frame_tick_d;
         hsync_s1_q          <= hsync_s1_d;
         vsync_s1_q          <= vsync_s1_d;
         hsync_q             <= hsync_d;
         vsync_q             <= vsync_d;
      end
   end

   // The last blanking line is excluded so a fresh grant always has at least a line to work in.
   assign grant_ok    = (v_cnt_q >= V_ACT_C) && (v_cnt_q != V_LAST_C);
   assign window_open = (v_cnt_q == V_ACT_C) && (h_cnt_q == '0);
   assign frame_end   = (v_cnt_q == V_LAST_C) && (h_cnt_q == H_LAST_C);

   always_ff @(posedge clock_25) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         update_grant_q   <= 1'b0;
         update_overrun_q <= 1'b0;
      end else begin
         update_overrun_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (update_req) begin
                  if (grant_ok) begin
                     state_q        <= ST_GRANTED;
                     update_grant_q <= 1'b1;
                  end else begin
                     state_q <= ST_PENDING;
                  end
               end
            end
            ST_PENDING: begin
               if (!update_req) begin
                  state_q <= ST_IDLE;
               end else if (window_open) begin
                  state_q        <= ST_GRANTED;
                  update_grant_q <= 1'b1;
               end
            end
            ST_GRANTED: begin
               // A request still held after release or revoke waits for the next frame's window.
               if (update_done || !update_req) begin
                  update_grant_q <= 1'b0;
                  state_q        <= update_req ? ST_PENDING : ST_IDLE;
               end else if (frame_end) begin
                  update_grant_q   <= 1'b0;
                  update_overrun_q <= 1'b1;
                  state_q          <= ST_PENDING;
               end
            end
            default: begin
               state_q        <= ST_IDLE;
               update_grant_q <= 1'b0;
            end
         endcase
      end
   end

   assign update_grant      = update_grant_q;
   assign update_overrun    = update_overrun_q;
   assign hsync             = hsync_q;
   assign vsync             = vsync_q;
   assign display_area      = display_area_q;
   assign game_enable       = game_enable_q;
   assign score_time_enable = score_time_enable_q;
   assign pixel_x           = pixel_x_q;
   assign pixel_y           = pixel_y_q;
   assign frame_tick        = frame_tick_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Directed bench for vga_frame_sequencer on a scaled raster (25x19 totals) so several frames fit a short run.
// Expected values are hand-derived from the scaled timing constants below.
module tb_vga_frame_sequencer;

   localparam int H_ACTIVE = 16;
   localparam int H_FP     = 2;
   localparam int H_SYNC   = 4;
   localparam int H_BP     = 3;
   localparam int V_ACTIVE = 12;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int SCORE_H  = 3;
   localparam int H_TOTAL  = 25;
   localparam int V_TOTAL  = 19;
   localparam int FRAME    = 475;

   logic       clock_25 = 1'b0;
   logic       reset = 1'b1;
   logic       game_running = 1'b0;
   logic       update_req = 1'b0;
   logic       update_done = 1'b0;
   logic       update_grant;
   logic       update_overrun;
   logic       hsync;
   logic       vsync;
   logic       display_area;
   logic       game_enable;
   logic       score_time_enable;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       frame_tick;

   vga_frame_sequencer #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SCORE_H(SCORE_H), .COORD_BIT(10)
   ) dut (
      .clock_25(clock_25),
      .reset(reset),
      .game_running(game_running),
      .update_req(update_req),
      .update_done(update_done),
      .update_grant(update_grant),
      .update_overrun(update_overrun),
      .hsync(hsync),
      .vsync(vsync),
      .display_area(display_area),
      .game_enable(game_enable),
      .score_time_enable(score_time_enable),
      .pixel_x(pixel_x),
      .pixel_y(pixel_y),
      .frame_tick(frame_tick)
   );

   always #20 clock_25 = ~clock_25;

   // Reference raster position: the counter value the DUT holds after each edge.
   int h_m = 0;
   int v_m = 0;
   always @(posedge clock_25) begin
      if (reset) begin
         h_m <= 0;
         v_m <= 0;
      end else if (h_m == H_TOTAL - 1) begin
         h_m <= 0;
         v_m <= (v_m == V_TOTAL - 1) ? 0 : v_m + 1;
      end else begin
         h_m <= h_m + 1;
      end
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int score_cnt, game_cnt, both_cnt, disp_cnt, tick_cnt, ovr_cnt, grant_cnt, coord_bad;
   int last_x, last_y;
   int hs_fall[$];
   int vs_fall[$];
   logic prev_hs = 1'b1;
   logic prev_vs = 1'b1;
   int c0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_counts();
      score_cnt = 0; game_cnt = 0; both_cnt = 0; disp_cnt = 0; tick_cnt = 0;
      ovr_cnt = 0; grant_cnt = 0; coord_bad = 0; last_x = -1; last_y = -1;
   endtask

   task automatic tick();
      @(negedge clock_25);
      cyc++;
      if (score_time_enable) score_cnt++;
      if (game_enable) game_cnt++;
      if (score_time_enable && game_enable) both_cnt++;
      if (display_area) begin
         disp_cnt++;
         last_x = int'(pixel_x);
         last_y = int'(pixel_y);
      end else if (pixel_x != 10'd0 || pixel_y != 10'd0) begin
         coord_bad++;
      end
      if (frame_tick) tick_cnt++;
      if (update_overrun) ovr_cnt++;
      if (update_grant) grant_cnt++;
      if (prev_hs && !hsync) hs_fall.push_back(cyc);
      if (prev_vs && !vsync) vs_fall.push_back(cyc);
      prev_hs = hsync;
      prev_vs = vsync;
   endtask

   task automatic wait_pos(input int v, input int h);
      int n = 0;
      do begin
         tick();
         n++;
      end while (!(v_m == v && h_m == h) && n < 2 * FRAME);
      if (!(v_m == v && h_m == h)) check_eq("wait_pos", v_m * 1000 + h_m, v * 1000 + h);
   endtask

   initial begin
      clear_counts();
      game_running = 1'b1;
      reset = 1'b1;
      repeat (3) tick();
      check_eq("rst_hsync", 32'(hsync), 1);
      check_eq("rst_vsync", 32'(vsync), 1);
      check_eq("rst_grant", 32'(update_grant), 0);
      check_eq("rst_disp", 32'(display_area), 0);
      check_eq("rst_px", 32'(pixel_x), 0);
      reset = 1'b0;
      c0 = cyc;
      hs_fall.delete();
      vs_fall.delete();

      // One full frame from release: enable areas and last visible pixel.
      clear_counts();
      repeat (FRAME) tick();
      check_eq("score_pixels", score_cnt, H_ACTIVE * SCORE_H);
      check_eq("game_pixels", game_cnt, H_ACTIVE * (V_ACTIVE - SCORE_H));
      check_eq("overlap", both_cnt, 0);
      check_eq("disp_pixels", disp_cnt, H_ACTIVE * V_ACTIVE);
      check_eq("coord_outside", coord_bad, 0);
      check_eq("last_x", last_x, H_ACTIVE - 1);
      check_eq("last_y", last_y, V_ACTIVE - 1);
      check_eq("frame_ticks", tick_cnt, 1);
      check_eq("hs_falls", hs_fall.size(), V_TOTAL);
      check_eq("first_hs", hs_fall[0] - c0, H_ACTIVE + H_FP + 2);
      check_eq("line_period", hs_fall[1] - hs_fall[0], H_TOTAL);
      check_eq("first_vs", vs_fall[0] - c0, (V_ACTIVE + V_FP) * H_TOTAL + 2);
      for (int n = 0; vs_fall.size() < 2 && n < 2 * FRAME; n++) tick();
      check_eq("vs_falls", vs_fall.size(), 2);
      if (vs_fall.size() >= 2) check_eq("frame_period", vs_fall[1] - vs_fall[0], FRAME);

      // game_running acts on the very next pixel.
      wait_pos(6, 2);
      game_running = 1'b0;
      tick();
      check_eq("gr_off_game", 32'(game_enable), 0);
      check_eq("gr_off_disp", 32'(display_area), 1);
      game_running = 1'b1;
      tick();
      check_eq("gr_on_game", 32'(game_enable), 1);

      // Request in active video waits for the blanking window; done outside grant is ignored.
      wait_pos(5, 0);
      update_req = 1'b1;
      wait_pos(8, 0);
      update_done = 1'b1;
      tick();
      update_done = 1'b0;
      wait_pos(12, 0);
      check_eq("pend_grant", 32'(update_grant), 0);
      tick();
      check_eq("win_grant", 32'(update_grant), 1);
      check_eq("win_ftick", 32'(frame_tick), 1);
      wait_pos(14, 0);
      update_done = 1'b1;
      update_req = 1'b0;
      tick();
      update_done = 1'b0;
      check_eq("done_grant", 32'(update_grant), 0);
      check_eq("done_ovr", 32'(update_overrun), 0);
      clear_counts();
      wait_pos(0, 5);
      check_eq("done_quiet_ovr", ovr_cnt, 0);
      check_eq("done_quiet_grant", grant_cnt, 0);

      // Held request without done: forced revoke at frame end, one overrun, regrant next window.
      wait_pos(5, 0);
      update_req = 1'b1;
      wait_pos(12, 1);
      check_eq("hold_grant", 32'(update_grant), 1);
      wait_pos(18, 24);
      check_eq("hold_last", 32'(update_grant), 1);
      clear_counts();
      tick();
      check_eq("revoke_grant", 32'(update_grant), 0);
      check_eq("revoke_ovr", 32'(update_overrun), 1);
      tick();
      check_eq("ovr_pulse_end", 32'(update_overrun), 0);
      wait_pos(12, 0);
      check_eq("ovr_count", ovr_cnt, 1);
      check_eq("regrant_wait", 32'(update_grant), 0);
      tick();
      check_eq("regrant", 32'(update_grant), 1);
      update_req = 1'b0;
      tick();
      check_eq("drop_req", 32'(update_grant), 0);

      // Request raised on the last blanking line is held off to the next frame.
      wait_pos(18, 0);
      update_req = 1'b1;
      clear_counts();
      wait_pos(12, 0);
      check_eq("late_no_grant", grant_cnt, 0);
      tick();
      check_eq("late_grant", 32'(update_grant), 1);
      wait_pos(13, 0);
      update_done = 1'b1;
      tick();
      update_done = 1'b0;
      check_eq("held_done_grant", 32'(update_grant), 0);
      clear_counts();
      wait_pos(15, 0);
      check_eq("held_pending", grant_cnt, 0);
      update_req = 1'b0;
      tick();
      wait_pos(16, 0);
      update_req = 1'b1;
      tick();
      check_eq("idle_vblank_grant", 32'(update_grant), 1);

      // Reset while granted in blanking.
      wait_pos(17, 0);
      reset = 1'b1;
      update_req = 1'b0;
      tick();
      check_eq("mid_rst_grant", 32'(update_grant), 0);
      check_eq("mid_rst_disp", 32'(display_area), 0);
      check_eq("mid_rst_game", 32'(game_enable), 0);
      check_eq("mid_rst_score", 32'(score_time_enable), 0);
      check_eq("mid_rst_hsync", 32'(hsync), 1);
      check_eq("mid_rst_vsync", 32'(vsync), 1);
      check_eq("mid_rst_ovr", 32'(update_overrun), 0);
      check_eq("mid_rst_py", 32'(pixel_y), 0);
      tick();
      reset = 1'b0;
      c0 = cyc;
      hs_fall.delete();
      clear_counts();
      for (int n = 0; hs_fall.size() < 1 && n < FRAME; n++) tick();
      check_eq("rst2_hs_seen", hs_fall.size(), 1);
      if (hs_fall.size() >= 1) check_eq("rst2_first_hs", hs_fall[0] - c0, H_ACTIVE + H_FP + 2);
      check_eq("rst2_ovr", ovr_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
